// File: rtl/step_counter_n.sv
// Tick-gated up/down counter with load, live terminal limit, wrap/saturate mode,
// multi-unit step, registered wrap pulse and sticky overflow/underflow flags.
module step_counter_n #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int INIT_W   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slow_edge,
    input  logic              load,
    input  logic              inc,
    input  logic              up,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    input  logic [INIT_W-1:0] init_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_limit,
    output logic              at_zero,
    output logic              wrap_pulse,
    output logic              ovf,
    output logic              unf
);

    // One extra bit so that count+STEP and count+limit+1 never truncate.
    localparam int XW = WIDTH + 1;
    typedef logic [XW-1:0] ext_t;
    localparam ext_t STEP_X = ext_t'(STEP);

    ext_t             lim_x;
    ext_t             base;
    ext_t             sum;
    ext_t             wrap_up;
    ext_t             pad_down;
    logic             do_step;
    logic             step_up;
    logic             set_ovf;
    logic             set_unf;
    logic [WIDTH-1:0] next_count;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        lim_x      = {1'b0, limit};
        base       = {1'b0, count};
        do_step    = 1'b0;
        step_up    = up;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        next_count = count;

        if (slow_edge) begin
            if (load) begin
                base = (load_val > limit) ? lim_x : {1'b0, load_val};
                if (inc) begin
                    do_step = 1'b1;
                    step_up = 1'b1;
                end else begin
                    next_count = base[WIDTH-1:0];
                end
            end else if (!inc) begin
                do_step = 1'b1;
            end
        end

        sum      = base + STEP_X;
        wrap_up  = sum - lim_x - ext_t'(1);
        pad_down = base + lim_x + ext_t'(1);

        if (do_step) begin
            if (limit == '0) begin
                next_count = '0;
                set_ovf    = step_up;
                set_unf    = !step_up;
            end else if (step_up) begin
                if (base > lim_x) begin
                    // Limit was lowered below the count: jump to the range edge.
                    set_ovf    = 1'b1;
                    next_count = SATURATE ? limit : '0;
                end else if (sum <= lim_x) begin
                    next_count = sum[WIDTH-1:0];
                end else begin
                    set_ovf = 1'b1;
                    if (SATURATE)            next_count = limit;
                    else if (wrap_up > lim_x) next_count = '0;
                    else                      next_count = wrap_up[WIDTH-1:0];
                end
            end else begin
                if (base >= STEP_X) begin
                    next_count = base[WIDTH-1:0] - STEP_X[WIDTH-1:0];
                end else begin
                    set_unf = 1'b1;
                    if (SATURATE)              next_count = '0;
                    else if (pad_down < STEP_X) next_count = limit;
                    else                        next_count = pad_down[WIDTH-1:0] - STEP_X[WIDTH-1:0];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= WIDTH'(init_val);
            wrap_pulse <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            count      <= next_count;
            wrap_pulse <= set_ovf | set_unf;
            ovf        <= set_ovf | (ovf & ~clr_flags);
            unf        <= set_unf | (unf & ~clr_flags);
        end
    end

    assign at_limit = (count == limit);
    assign at_zero  = (count == '0);

endmodule

// File: tb/tb_step_counter_n.sv
// Scoreboard bench: three counters (step 1 wrap, step 3 wrap, step 1 saturate);
// the driver queues expected outputs, a monitor pops and compares after each edge.
module tb_step_counter_n;

    logic       clk = 1'b0;
    logic       rst_v  [3];
    logic       se_v   [3];
    logic       ld_v   [3];
    logic       inc_v  [3];
    logic       up_v   [3];
    logic [7:0] lv_v   [3];
    logic [7:0] lim_v  [3];
    logic [1:0] init_v [3];
    logic       clr_v  [3];
    logic [7:0] cnt_o  [3];
    logic       atl_o  [3];
    logic       atz_o  [3];
    logic       pulse_o[3];
    logic       ovf_o  [3];
    logic       unf_o  [3];

    typedef struct {
        int         id;
        logic [7:0] cnt;
        logic       pulse;
        logic       ovf;
        logic       unf;
        logic       atl;
        logic       atz;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    step_counter_n #(.WIDTH(8), .STEP(1), .INIT_W(2), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(rst_v[0]), .slow_edge(se_v[0]), .load(ld_v[0]), .inc(inc_v[0]),
        .up(up_v[0]), .load_val(lv_v[0]), .limit(lim_v[0]), .init_val(init_v[0]),
        .clr_flags(clr_v[0]), .count(cnt_o[0]), .at_limit(atl_o[0]), .at_zero(atz_o[0]),
        .wrap_pulse(pulse_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]));

    step_counter_n #(.WIDTH(8), .STEP(3), .INIT_W(2), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(rst_v[1]), .slow_edge(se_v[1]), .load(ld_v[1]), .inc(inc_v[1]),
        .up(up_v[1]), .load_val(lv_v[1]), .limit(lim_v[1]), .init_val(init_v[1]),
        .clr_flags(clr_v[1]), .count(cnt_o[1]), .at_limit(atl_o[1]), .at_zero(atz_o[1]),
        .wrap_pulse(pulse_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]));

    step_counter_n #(.WIDTH(8), .STEP(1), .INIT_W(2), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(rst_v[2]), .slow_edge(se_v[2]), .load(ld_v[2]), .inc(inc_v[2]),
        .up(up_v[2]), .load_val(lv_v[2]), .limit(lim_v[2]), .init_val(init_v[2]),
        .clr_flags(clr_v[2]), .count(cnt_o[2]), .at_limit(atl_o[2]), .at_zero(atz_o[2]),
        .wrap_pulse(pulse_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]));

    // Drives one cycle of stimulus on a single counter and queues what it must show next.
    task automatic drv(input int id, input logic rst, input logic se, input logic ld,
                       input logic inc, input logic up, input logic [7:0] lv,
                       input logic [7:0] lim, input logic clr, input logic [7:0] ec,
                       input logic ep, input logic eo, input logic eu, input string nm);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            se_v[k]  = 1'b0;
            ld_v[k]  = 1'b0;
            clr_v[k] = 1'b0;
        end
        rst_v[id] = rst;
        se_v[id]  = se;
        ld_v[id]  = ld;
        inc_v[id] = inc;
        up_v[id]  = up;
        lv_v[id]  = lv;
        lim_v[id] = lim;
        clr_v[id] = clr;
        e.id = id;
        e.cnt = ec;
        e.pulse = ep;
        e.ovf = eo;
        e.unf = eu;
        e.atl = (ec == lim);
        e.atz = (ec == 8'd0);
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({cnt_o[e.id], pulse_o[e.id], ovf_o[e.id], unf_o[e.id], atl_o[e.id], atz_o[e.id]} !==
                    {e.cnt, e.pulse, e.ovf, e.unf, e.atl, e.atz}) begin
                    errors++;
                    $display("FAIL %s dut%0d: got cnt=%0d pulse=%b ovf=%b unf=%b atl=%b atz=%b, want cnt=%0d pulse=%b ovf=%b unf=%b atl=%b atz=%b",
                             e.name, e.id, cnt_o[e.id], pulse_o[e.id], ovf_o[e.id], unf_o[e.id],
                             atl_o[e.id], atz_o[e.id], e.cnt, e.pulse, e.ovf, e.unf, e.atl, e.atz);
                end
            end
        end
    end

    initial begin : stimulus
        int w;
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b0; se_v[k] = 1'b0; ld_v[k] = 1'b0; inc_v[k] = 1'b0;
            up_v[k] = 1'b1; lv_v[k] = 8'd0; clr_v[k] = 1'b0; init_v[k] = 2'b11;
        end
        lim_v[0] = 8'd255; lim_v[1] = 8'd9; lim_v[2] = 8'd9;

        //  id rst se ld inc up  lv   lim  clr  cnt  p  o  u
        drv(0, 0, 0, 0, 0, 1,   0, 255, 0,   3, 0, 0, 0, "reset_a");
        drv(1, 0, 0, 0, 0, 1,   0,   9, 0,   3, 0, 0, 0, "reset_b");
        drv(2, 0, 0, 0, 0, 1,   0,   9, 0,   3, 0, 0, 0, "reset_c");

        // Counter A: step 1, wrap, 8-bit full range
        for (int i = 0; i < 10; i++)
            drv(0, 1, 0, 0, 0, 1,   0, 255, 0,   3, 0, 0, 0, "a_idle_hold");
        drv(0, 1, 1, 1, 0, 1, 255, 255, 0, 255, 0, 0, 0, "a_load_255");
        drv(0, 1, 1, 0, 0, 1,   0, 255, 0,   0, 1, 1, 0, "a_up_wrap");
        drv(0, 1, 0, 0, 0, 1,   0, 255, 0,   0, 0, 1, 0, "a_pulse_drop");
        drv(0, 1, 0, 0, 0, 1,   0, 255, 1,   0, 0, 0, 0, "a_clr_flags");
        drv(0, 1, 1, 0, 0, 0,   0, 255, 0, 255, 1, 0, 1, "a_down_wrap");
        drv(0, 1, 1, 0, 0, 1,   0, 255, 1,   0, 1, 1, 0, "a_clr_vs_set");
        drv(0, 0, 1, 0, 0, 1,   0, 255, 0,   3, 0, 0, 0, "a_reset_mid_step");
        drv(0, 1, 1, 0, 0, 1,   0,   2, 0,   0, 1, 1, 0, "a_up_above_limit");
        drv(0, 1, 1, 0, 0, 0,   0,   0, 0,   0, 1, 1, 1, "a_limit0_down");
        drv(0, 1, 1, 0, 1, 1,   0,   0, 0,   0, 0, 1, 1, "a_inc_hold");

        // Counter B: step 3, wrap, limit 9
        drv(1, 1, 1, 1, 0, 1,   8,   9, 0,   8, 0, 0, 0, "b_load_8");
        drv(1, 1, 1, 0, 0, 1,   0,   9, 0,   1, 1, 1, 0, "b_up_wrap");
        drv(1, 1, 1, 0, 0, 0,   0,   9, 0,   8, 1, 1, 1, "b_down_wrap");
        drv(1, 1, 1, 0, 0, 1,   0,   1, 0,   0, 1, 1, 1, "b_up_over_lowered");
        drv(1, 1, 1, 0, 0, 0,   0,   1, 0,   1, 1, 1, 1, "b_down_step_gt_range");
        drv(1, 1, 0, 0, 0, 1,   0,   9, 1,   1, 0, 0, 0, "b_clr");
        drv(1, 1, 1, 0, 0, 1,   0,   9, 0,   4, 0, 0, 0, "b_up_plain");

        // Counter C: step 1, saturate
        drv(2, 1, 1, 1, 0, 1,   9,   9, 0,   9, 0, 0, 0, "c_load_9");
        drv(2, 1, 1, 0, 0, 1,   0,   9, 0,   9, 1, 1, 0, "c_sat_top");
        drv(2, 1, 0, 0, 0, 1,   0,   9, 0,   9, 0, 1, 0, "c_pulse_drop");
        drv(2, 1, 1, 1, 0, 1,   0,   9, 0,   0, 0, 1, 0, "c_load_0");
        drv(2, 1, 1, 0, 0, 0,   0,   9, 0,   0, 1, 1, 1, "c_sat_bottom");
        drv(2, 1, 1, 1, 1, 1,   7, 200, 0,   8, 0, 1, 1, "c_load_inc");
        drv(2, 1, 1, 1, 0, 1, 250, 200, 0, 200, 0, 1, 1, "c_load_clamped");
        drv(2, 1, 0, 1, 0, 1,   5, 200, 0, 200, 0, 1, 1, "c_load_no_tick");
        drv(2, 1, 0, 0, 0, 1,   0, 200, 1, 200, 0, 0, 0, "c_clr");
        drv(2, 1, 1, 1, 1, 1, 250, 200, 0, 200, 1, 1, 0, "c_load_inc_ovf");
        drv(2, 1, 1, 0, 1, 1,   0, 200, 0, 200, 0, 1, 0, "c_inc_hold");
        drv(2, 1, 1, 0, 0, 0,   0, 200, 0, 199, 0, 1, 0, "c_down_plain");

        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
